lfsr_toggle_gen: RTL
====================

# lfsr_toggle_gen

Parameterised XNOR Fibonacci LFSR that drives the LED demultiplexer stage with a pseudo-random toggle. It steps once per cycle while `i_Enable` is high. When the register returns to its loaded seed, it flags the completed period and flips `o_LFSR_Toggle`, the signal the demux routes to the LEDs. `i_Enable` is normally tied to the slow count-and-toggle tick, so the LED pattern is visible.

## Interface
- NUM_BITS, 8, LFSR width; legal range 3..12; any other value is a synthesis error.
- i_Clk  in  1  system clock; all state changes on the rising edge.
- i_Rst_L  in  1  reset; asynchronous, active-low.
- i_Enable  in  1  advance LFSR one step on this edge.
- i_Seed_DV  in  1  load `i_Seed_Data` on this edge; has priority over `i_Enable`.
- i_Seed_Data  in  NUM_BITS  seed value.
- o_LFSR_Data  out  NUM_BITS  current LFSR state, registered.
- o_LFSR_Done  out  1  one-cycle pulse; high in the cycle where `o_LFSR_Data` has just returned to the seed.
- o_LFSR_Toggle  out  1  flips on every `o_LFSR_Done`; feeds demux `i_Data`.

## Operation
- State: `r_LFSR[NUM_BITS-1:0]` and `r_Seed[NUM_BITS-1:0]`.
- Step function: `fb = XNOR` of tap bits; `next = {r_LFSR[NUM_BITS-2:0], fb}`.
- Taps are 1-indexed; tap n is bit n-1:
  - 3: 3,2
  - 4: 4,3
  - 5: 5,3
  - 6: 6,5
  - 7: 7,6
  - 8: 8,6,5,4
  - 9: 9,5
  - 10: 10,7
  - 11: 11,9
  - 12: 12,6,4,1
- Period is 2^NUM_BITS − 1. The all-ones state is the lockup state and is never entered by stepping.
- Seed load (`i_Seed_DV=1`):
  - `r_LFSR <= i_Seed_Data` and `r_Seed <= i_Seed_Data`.
  - If `i_Seed_Data` is all-ones, both registers load all-zeros instead.
  - `o_LFSR_Done` is 0 that cycle.
  - `o_LFSR_Toggle` is unchanged.
- Step (`i_Enable=1`, `i_Seed_DV=0`):
  - `r_LFSR <= next`.
  - `o_LFSR_Done <= (next == r_Seed)`.
  - If `next == r_Seed`, `o_LFSR_Toggle` inverts.
- Idle (`i_Enable=0`, `i_Seed_DV=0`): `r_LFSR` holds, and `o_LFSR_Done <= 0`.
- Simultaneous `i_Seed_DV` and `i_Enable`: the load wins and no step occurs.
- Control FSM, two states:
  - LOADED: entered on reset or seed load. Moves to RUNNING on the first step.
  - RUNNING: returns to LOADED on a seed load.
  - Both states share the step logic. The state is exposed only for assertions.

## Timing
- Reset (i_Rst_L=0, asynchronous):
  - `o_LFSR_Data` = 0
  - `r_Seed` = 0
  - `o_LFSR_Done` = 0
  - `o_LFSR_Toggle` = 0
  - FSM = LOADED
- Release is synchronous to the first following rising edge. An enable on that edge steps normally.
- Latency is one cycle from an enable edge to the updated `o_LFSR_Data`. `o_LFSR_Done` is aligned with the `o_LFSR_Data` value that equals the seed.
- Done spacing: with `i_Enable` held high, `o_LFSR_Done` pulses exactly every 2^NUM_BITS − 1 cycles. It is never high on two consecutive cycles.
- Enable gaps stretch the period. Done counts steps, not cycles.
- Reset asserted mid-sequence: all outputs clear immediately, without waiting for a clock edge. The sequence restarts from seed 0.
- Seed load mid-sequence: the period restarts from the new seed. The next done is 2^NUM_BITS − 1 steps later.

## Test plan
- NUM_BITS=3, reset, then `i_Enable=1`. Required `o_LFSR_Data`: 001, 011, 110, 101, 010, 100, 000. `o_LFSR_Done=1` only on 000, and `o_LFSR_Toggle` goes 0→1 there. The sequence repeats, and the toggle returns to 0 after 14 steps.
- NUM_BITS=8, seed 0x5A, `i_Enable=1` for 600 cycles. Required:
  - 255 distinct states, with 0xFF never seen.
  - done pulses exactly 255 cycles apart.
  - 2 toggles.
- NUM_BITS=3, load seed 111. Required: `o_LFSR_Data`=000 and `r_Seed`=000. The next step gives 001.
- NUM_BITS=3, `i_Seed_DV` and `i_Enable` both high with seed 010. Required: `o_LFSR_Data`=010, no step, `o_LFSR_Done`=0. The next steps give 100, 000, 001.
- NUM_BITS=4 with random `i_Enable` duty of 30%. Required: done after exactly 15 enabled steps each period, and `o_LFSR_Data` frozen while enable is low.
- Drop `i_Rst_L` between clock edges while `o_LFSR_Toggle=1` and `o_LFSR_Data`≠0. Required: all outputs read 0 before the next rising edge.

Source files
------------

// File: rtl/lfsr_toggle_gen.sv
// XNOR Fibonacci LFSR that pulses o_LFSR_Done and flips o_LFSR_Toggle each time
// the register steps back around to the seed it was loaded with.
module lfsr_toggle_gen #(
   parameter int NUM_BITS = 8
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_Enable,
   input  logic                i_Seed_DV,
   input  logic [NUM_BITS-1:0] i_Seed_Data,
   output logic [NUM_BITS-1:0] o_LFSR_Data,
   output logic                o_LFSR_Done,
   output logic                o_LFSR_Toggle
);

   if (NUM_BITS < 3 || NUM_BITS > 12) begin : g_width_check
      $error("lfsr_toggle_gen: NUM_BITS must be in 3..12");
   end

   // Maximal-length tap sets; bit n-1 set for 1-indexed tap n.
   function automatic logic [11:0] taps_for(input int n);
      case (n)
         3:       return 12'h006;
         4:       return 12'h00C;
         5:       return 12'h014;
         6:       return 12'h030;
         7:       return 12'h060;
         8:       return 12'h0B8;
         9:       return 12'h110;
         10:      return 12'h240;
         11:      return 12'h500;
         12:      return 12'h829;
         default: return 12'h000;
      endcase
   endfunction

   localparam logic [11:0]         TAPS_ALL = taps_for(NUM_BITS);
   localparam logic [NUM_BITS-1:0] TAP_MASK = TAPS_ALL[NUM_BITS-1:0];

   typedef enum logic {ST_LOADED, ST_RUNNING} state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
   logic [NUM_BITS-1:0] seed_q, seed_d;
   logic [NUM_BITS-1:0] lfsr_next, seed_in;
   logic                fb;
   logic                done_q, done_d;
   logic                toggle_q, toggle_d;
   logic                in_loaded;

   // Every tap set has an even tap count, so the XNOR chain reduces to inverted parity.
   always_comb begin
      fb        = ~(^(lfsr_q & TAP_MASK));
      lfsr_next = {lfsr_q[NUM_BITS-2:0], fb};
      seed_in   = (&i_Seed_Data) ? '0 : i_Seed_Data;
   end

   always_comb begin
      lfsr_d   = lfsr_q;
      seed_d   = seed_q;
      done_d   = 1'b0;
      toggle_d = toggle_q;
      if (i_Seed_DV) begin
         lfsr_d = seed_in;
         seed_d = seed_in;
      end else if (i_Enable) begin
         lfsr_d = lfsr_next;
         if (lfsr_next == seed_q) begin
            done_d   = 1'b1;
            toggle_d = ~toggle_q;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         lfsr_q   <= '0;
         seed_q   <= '0;
         done_q   <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         seed_q   <= seed_d;
         done_q   <= done_d;
         toggle_q <= toggle_d;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) state_q <= ST_LOADED;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOADED:  if (!i_Seed_DV && i_Enable) state_d = ST_RUNNING;
         ST_RUNNING: if (i_Seed_DV) state_d = ST_LOADED;
         default:    state_d = ST_LOADED;
      endcase
   end

   always_comb begin
      in_loaded = (state_q == ST_LOADED);
   end

   // Until the first step the register must still hold the seed it was loaded with.
   always_ff @(posedge i_Clk) begin
      if (i_Rst_L) begin
         if (in_loaded) assert (lfsr_q == seed_q);
         assert (!(done_q && done_d));
      end
   end

   assign o_LFSR_Data   = lfsr_q;
   assign o_LFSR_Done   = done_q;
   assign o_LFSR_Toggle = toggle_q;

endmodule
